spi_i2c_cmd_seq: RTL

Command sequencer between the SPI slave RX FIFO and the I2C master engine of the SPI-to-I2C bridge. Pops framed command bytes written by the SPI host, decodes each frame into one I2C transaction request, streams write payload to the I2C master and tracks completion. On NACK it drains the unused payload, so the next frame stays byte-aligned.

---
 rtl/spi_i2c_cmd_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_i2c_cmd_seq.sv
// SPI RX FIFO to I2C master command sequencer: decodes {rw,addr},len,payload frames.
// Optional payload-starvation watchdog with i2c_abort when SEQ_TIMEOUT_EN is defined.
module spi_i2c_cmd_seq #(
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic [7:0]       fifo_rd_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             i2c_cmd_valid,
    input  logic             i2c_cmd_ready,
    output logic [6:0]       i2c_addr,
    output logic             i2c_rw,
    output logic [LEN_W-1:0] i2c_len,
    output logic             i2c_wdata_valid,
    input  logic             i2c_wdata_ready,
    output logic [7:0]       i2c_wdata,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             i2c_abort,
    output logic             busy,
    output logic             err_nack,
    output logic             err_len,
    output logic [15:0]      frame_cnt
);
    typedef enum logic [2:0] {IDLE, LEN, CMD, DATA, WAIT, FLUSH} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_byte;
    logic             xfer;
    logic             pop;

    assign len_byte        = LEN_W'(fifo_rd_data);
    assign i2c_wdata       = fifo_rd_data;
    assign i2c_wdata_valid = (state == DATA) & ~fifo_empty;
    assign xfer            = i2c_wdata_valid & i2c_wdata_ready;
    assign cnt_nxt         = cnt - {{(LEN_W-1){1'b0}}, xfer};
    assign busy            = (state != IDLE);

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE, LEN: pop = ~fifo_empty;
            DATA:      pop = xfer;
            FLUSH:     pop = ~fifo_empty & (cnt != '0);
            default:   pop = 1'b0;
        endcase
    end

    // Gated by reset so the FIFO is never popped while the sequencer is held in reset.
    assign fifo_rd_en = pop & wr_rst_n;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign i2c_abort      = 1'b0;
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            i2c_cmd_valid <= 1'b0;
            i2c_addr      <= '0;
            i2c_rw        <= 1'b0;
            i2c_len       <= '0;
            err_nack      <= 1'b0;
            err_len       <= 1'b0;
            frame_cnt     <= '0;
`ifdef SEQ_TIMEOUT_EN
            i2c_abort     <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            err_len <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            i2c_abort <= 1'b0;
            wd_cnt    <= (state == DATA && fifo_empty) ? wd_cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: if (!fifo_empty) begin
                    i2c_rw   <= fifo_rd_data[7];
                    i2c_addr <= fifo_rd_data[6:0];
                    state    <= LEN;
                end
                LEN: if (!fifo_empty) begin
                    if (len_byte == '0) begin
                        err_len <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        i2c_len       <= len_byte;
                        cnt           <= len_byte;
                        i2c_cmd_valid <= 1'b1;
                        state         <= CMD;
                    end
                end
                CMD: if (i2c_cmd_ready) begin
                    i2c_cmd_valid <= 1'b0;
                    state         <= i2c_rw ? WAIT : DATA;
                end
                DATA: begin
                    cnt <= cnt_nxt;
                    if (i2c_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (i2c_nack) begin
                            err_nack <= 1'b1;
                            // Unsent payload must be drained to keep the next header aligned.
                            state    <= (cnt_nxt != '0) ? FLUSH : IDLE;
                        end else begin
                            state    <= IDLE;
                        end
                    end else if (xfer && cnt == LEN_W'(1)) begin
                        state <= WAIT;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (fifo_empty && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        i2c_abort <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                end
                WAIT: if (i2c_done) begin
                    frame_cnt <= frame_cnt + 16'd1;
                    if (i2c_nack) err_nack <= 1'b1;
                    state <= IDLE;
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else if (!fifo_empty) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
